// File: rtl/girlanda_timer.sv
// girlanda_timer: debounced mode selector, tick prescaler and saturating step counter.
// Define GIRLANDA_AUTOCYCLE_EN to advance the mode automatically every AUTO_STEPS steps.
module girlanda_timer #(
  parameter int PRESCALE   = 1000,
  parameter int STEP_TICKS = 25,
  parameter int DEB_CYCLES = 16,
  parameter int AUTO_STEPS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        count_clr_n,
  output logic [1:0]  mode,
  output logic [31:0] count,
  output logic        step,
  output logic        mode_chg
);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DEB_HI, HELD, DEB_LO} deb_t;
  deb_t st, st_nx;
  logic s1, btn_s, btn_acc, auto_acc, acc, tick;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [PW-1:0] pre;
  logic [1:0] mode_nx;
  always_comb begin
    st_nx   = st;
    dcnt_nx = dcnt;
    btn_acc = 1'b0;
    case (st)
      IDLE: if (btn_s) begin
        st_nx   = DEB_HI;
        dcnt_nx = DW'(1);
      end
      DEB_HI: if (!btn_s) begin
        st_nx   = IDLE;
        dcnt_nx = '0;
      end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        st_nx   = HELD;
        dcnt_nx = '0;
        btn_acc = 1'b1;
      end else dcnt_nx = dcnt + DW'(1);
      HELD: if (!btn_s) begin
        st_nx   = DEB_LO;
        dcnt_nx = DW'(1);
      end
      default: if (btn_s) begin
        st_nx   = HELD;
        dcnt_nx = '0;
      end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        st_nx   = IDLE;
        dcnt_nx = '0;
      end else dcnt_nx = dcnt + DW'(1);
    endcase
  end
`ifdef GIRLANDA_AUTOCYCLE_EN
  localparam int AW = $clog2(AUTO_STEPS + 1);
  logic [AW-1:0] scnt;
  assign auto_acc = step && mode != 2'd2 && scnt == AW'(AUTO_STEPS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) scnt <= '0;
    else if (btn_acc || auto_acc) scnt <= '0;
    else if (step && mode != 2'd2) scnt <= scnt + AW'(1);
`else
  assign auto_acc = AUTO_STEPS < 0;
`endif
  assign acc  = btn_acc | auto_acc;
  assign tick = pre == PW'(PRESCALE - 1);
  // the automatic advance toggles between chase and ping-pong, never turning the garland off
  assign mode_nx = btn_acc ? (mode == 2'd2 ? 2'd0 : mode + 2'd1) : (mode == 2'd0 ? 2'd1 : 2'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1       <= 1'b0;
      btn_s    <= 1'b0;
      st       <= IDLE;
      dcnt     <= '0;
      mode     <= 2'd0;
      mode_chg <= 1'b0;
      step     <= 1'b0;
      pre      <= '0;
      count    <= '0;
    end else begin
      s1       <= btn_mode;
      btn_s    <= s1;
      st       <= st_nx;
      dcnt     <= dcnt_nx;
      mode_chg <= acc;
      step     <= !acc && mode != 2'd2 && count_clr_n && tick && count == 32'(STEP_TICKS - 1);
      if (acc) begin
        mode  <= mode_nx;
        pre   <= '0;
        count <= '0;
      end else if (mode == 2'd2) begin
        pre   <= '0;
        count <= '0;
      end else begin
        pre <= tick ? '0 : pre + PW'(1);
        if (!count_clr_n) count <= '0;
        else if (tick && count < 32'(STEP_TICKS)) count <= count + 32'd1;
      end
    end
endmodule

// File: tb/tb_girlanda_timer.sv
// tb_girlanda_timer: scoreboard bench; expectations are queued with their due cycle as stimulus is driven.
module tb_girlanda_timer;
  localparam int P = 4, ST = 25, DEB = 4, AS = 3;
  logic clk = 0, rst_n = 1, btn_mode = 0, clr_drv = 1, tie = 0;
  logic count_clr_n, step, mode_chg;
  logic [1:0] mode;
  logic [31:0] count;
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {int at; int sel; logic [31:0] v; string tag;} exp_t;
  exp_t q[$];
  assign count_clr_n = tie ? ~step : clr_drv;
  girlanda_timer #(.PRESCALE(P), .STEP_TICKS(ST), .DEB_CYCLES(DEB), .AUTO_STEPS(AS)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .count_clr_n(count_clr_n),
    .mode(mode), .count(count), .step(step), .mode_chg(mode_chg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void exp_at(input int at, input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    int i;
    e = '{at, sel, v, tag};
    i = q.size();
    while (i > 0 && q[i-1].at > at) i--;
    q.insert(i, e);
  endfunction
  function automatic logic [31:0] obs(input int sel);
    return sel == 0 ? 32'(mode) : sel == 1 ? count : sel == 2 ? 32'(step) : 32'(mode_chg);
  endfunction
  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, obs(e.sel), e.v);
    end
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
`ifdef GIRLANDA_AUTOCYCLE_EN
  int nsteps = 0;
  always @(posedge clk) begin
    #1;
    if (step) nsteps++;
  end
`endif
  initial begin
    int b, a, cc, t1, t10, x, r, n;
    #2 rst_n = 0;
    wait_n(3);
    check("rst_mode", 32'(mode), 0);
    check("rst_count", count, 0);
    check("rst_step", 32'(step), 0);
    check("rst_chg", 32'(mode_chg), 0);
    rst_n = 1;
    b = cyc;
    exp_at(b + P - 1, 1, 0, "tick_wait");
    exp_at(b + P, 1, 1, "first_tick");
    exp_at(b + 2 * P, 1, 2, "second_tick");
    wait_n(10);
    b = cyc;
    btn_mode = 1;
    for (int d = 1; d <= 14; d++) exp_at(b + d, 3, 0, "bounce_chg");
    exp_at(b + 14, 0, 0, "bounce_mode");
    wait_n(DEB - 1);
    btn_mode = 0;
    wait_n(14);
    b = cyc;
    a = b + DEB + 2;
    btn_mode = 1;
    exp_at(a - 1, 0, 0, "pre_accept_mode");
    exp_at(a, 0, 1, "accept_mode");
    exp_at(a - 1, 3, 0, "pre_accept_chg");
    exp_at(a, 3, 1, "accept_chg");
    exp_at(a + 1, 3, 0, "chg_len");
    exp_at(a, 1, 0, "accept_count");
    exp_at(a + P, 1, 1, "tick_after_accept");
    for (int d = 1; d <= 100; d++) exp_at(a + d, 0, 1, "hold_mode");
    exp_at(a + ST * P - 1, 1, ST - 1, "count_pre_step");
    exp_at(a + ST * P - 1, 2, 0, "step_early");
    exp_at(a + ST * P, 1, ST, "count_step");
    exp_at(a + ST * P, 2, 1, "step");
    for (int d = 1; d <= 44; d++) exp_at(a + ST * P + d, 2, 0, "step_once");
    exp_at(a + ST * P + 40, 1, ST, "saturate");
    wait_n(a + 100 - cyc);
    btn_mode = 0;
    wait_n(a + ST * P + 45 - cyc);
    cc = cyc;
    t1 = cc + 2;
    while ((t1 - a) % P != 0) t1++;
    t10 = t1 + 9 * P;
    x = t10 + P;
    exp_at(cc + 1, 1, 0, "clear");
    exp_at(t1 - 1, 1, 0, "clear_hold");
    exp_at(t1, 1, 1, "tick_after_clear");
    exp_at(t1 + P, 1, 2, "tick2_after_clear");
    exp_at(t10, 1, 10, "count_10");
    exp_at(x, 1, 0, "collision");
    exp_at(x + P - 1, 1, 0, "collision_lost");
    exp_at(x + P, 1, 1, "after_collision");
    clr_drv = 0;
    wait_n(1);
    clr_drv = 1;
    wait_n(x - 1 - cyc);
    clr_drv = 0;
    wait_n(1);
    clr_drv = 1;
    r = x + 7 * P + 1;
    exp_at(r, 1, 7, "pre_reset_count");
    exp_at(r, 0, 1, "pre_reset_mode");
    wait_n(r - cyc);
    rst_n = 0;
    #1;
    check("async_rst_mode", 32'(mode), 0);
    check("async_rst_count", count, 0);
    check("async_rst_step", 32'(step), 0);
    wait_n(2);
    rst_n = 1;
    b = cyc;
    exp_at(b + P - 1, 1, 0, "rst_tick_wait");
    exp_at(b + P, 1, 1, "rst_first_tick");
    wait_n(P + 2);
    b = cyc;
    btn_mode = 1;
    exp_at(b + DEB + 2, 0, 1, "to_mode1");
    wait_n(DEB + 4);
    btn_mode = 0;
    wait_n(DEB + 6);
    b = cyc;
    a = b + DEB + 2;
    btn_mode = 1;
    exp_at(a, 0, 2, "to_off");
    exp_at(a, 1, 0, "off_count");
    exp_at(a, 3, 1, "off_chg");
    for (int d = 1; d <= 1000; d++) begin
      exp_at(a + d, 2, 0, "off_step");
      if (d % 100 == 0) begin
        exp_at(a + d, 1, 0, "off_count_hold");
        exp_at(a + d, 0, 2, "off_mode_hold");
      end
    end
    wait_n(DEB + 4);
    btn_mode = 0;
    wait_n(a + 1000 - cyc);
    b = cyc;
    a = b + DEB + 2;
    btn_mode = 1;
    exp_at(a, 0, 0, "off_to_chase");
    exp_at(a, 3, 1, "off_to_chase_chg");
    exp_at(a, 1, 0, "off_to_chase_count");
    exp_at(a + P, 1, 1, "run_after_off");
    wait_n(DEB + 4);
    btn_mode = 0;
    wait_n(DEB + 8);
`ifdef GIRLANDA_AUTOCYCLE_EN
    begin
      int s0;
      s0 = nsteps;
      tie = 1;
      for (int k = 0; k < 2; k++) begin
        n = 0;
        do begin
          wait_n(1);
          n++;
        end while (!mode_chg && n < 2000);
        check("auto_chg_seen", 32'(mode_chg), 1);
        check("auto_mode", 32'(mode), k == 0 ? 1 : 0);
        check("auto_steps", 32'(nsteps - s0), 32'(AS * (k + 1)));
      end
      tie = 0;
    end
`endif
    n = 0;
    while (q.size() > 0 && n < 200) begin
      wait_n(1);
      n++;
    end
    if (q.size() > 0) check("drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end
endmodule

// File: doc/girlanda_timer.md
# girlanda_timer

Timebase and mode selector for the garland pattern generator. It debounces the user mode button and produces the 2-bit pattern mode. It also divides the system clock into pattern ticks and maintains the 32-bit step counter that the downstream pattern stage compares against its step threshold. The downstream stage acknowledges each consumed step through an active-low clear request, which closes the loop.

## Interface
- PRESCALE, 1000: clk cycles per tick (≥2).
- STEP_TICKS, 25: count value at which a step is due; count saturates here.
- DEB_CYCLES, 16: consecutive stable synchronized samples required to accept a button level change (≥2).
- AUTO_STEPS, 64: steps per mode before automatic advance. Only used when GIRLANDA_AUTOCYCLE_EN is defined.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw, asynchronous, bouncing mode button, active-high.
- count_clr_n  in  1  active-low step acknowledge from the pattern stage; low clears count.
- mode  out  2  pattern mode: 0 = running chase, 1 = ping-pong, 2 = off; 3 is never driven.
- count  out  32  tick counter feeding the pattern stage.
- step  out  1  one-cycle pulse on the cycle count becomes STEP_TICKS.
- mode_chg  out  1  one-cycle pulse on the cycle mode changes.

## Operation
- Reset values: mode=0, count=0, step=0, mode_chg=0. Prescaler=0, debounce FSM=IDLE, debounce counter=0, synchronizer flops=0.
- The synchronizer is two flops on btn_mode. Only the second flop (btn_s) feeds logic.
- Debounce FSM:
  - IDLE (stable low): when btn_s=1, go to DEB_HI with counter=1.
  - DEB_HI: when btn_s=1, increment. When the counter reaches DEB_CYCLES, go to HELD and raise an accept pulse. When btn_s=0, return to IDLE and clear the counter.
  - HELD (stable high): when btn_s=0, go to DEB_LO with counter=1.
  - DEB_LO: mirror of DEB_HI. Reaching DEB_CYCLES goes to IDLE; btn_s=1 returns to HELD. No pulse is raised.
- Accept pulse: mode advances 0→1→2→0, mode_chg=1 for one cycle, and prescaler and count are cleared to 0 in the same cycle.
- Prescaler counts 0..PRESCALE-1 and wraps. The wrap cycle is a tick.
- count update priority, highest first:
  1. mode change
  2. mode==2 (count held at 0, prescaler held at 0)
  3. count_clr_n==0 (count←0)
  4. tick with count<STEP_TICKS (count←count+1)
  5. hold
- count saturates at STEP_TICKS and never wraps. Further ticks are ignored until cleared.
- step is registered: it is 1 in the cycle after the edge on which count goes from STEP_TICKS-1 to STEP_TICKS. A clear in that same cycle does not suppress it.
- Simultaneous clear and tick: the clear wins and the tick is lost. The prescaler keeps running.
- A button accept in mode 2 returns to mode 0 with count=0.
- Reset mid-operation: all state returns to reset values immediately (async). The first tick arrives PRESCALE cycles after rst_n deasserts.

## Timing
- Button to mode: btn_mode is held high from cycle 0 (sampled at edge 1). mode and mode_chg update at edge 2+DEB_CYCLES. Total latency is DEB_CYCLES+2 cycles.
- A bounce shorter than DEB_CYCLES samples produces no mode change.
- Tick period is exactly PRESCALE cycles while the block is not cleared or off.
- The first step after a clear arrives STEP_TICKS×PRESCALE cycles after the prescaler restarts from 0. A clear that leaves the prescaler running makes the first tick sooner.
- count_clr_n has a single-cycle effect. It is level-sensitive, so while held low, count stays 0.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- GIRLANDA_AUTOCYCLE_EN defined:
  - A step counter counts step pulses in modes 0 and 1.
  - At AUTO_STEPS it generates an internal accept, with the same effect as a button accept, and restarts from 0.
  - Any button accept also resets it.
  - Mode 2 is never entered automatically: the advance from 1 goes to 0.
- Not defined: the step counter and auto logic are absent. Mode changes only on button accept.

## Test plan
- Reset: assert rst_n=0 mid-count (count=7, mode=1) → mode=0, count=0, step=0 immediately. First tick PRESCALE cycles after release.
- Debounce (DEB_CYCLES=4): pulse btn_mode high for 3 cycles → no mode change. Then hold high → mode 0→1 and mode_chg=1 exactly 6 cycles after the first sampled high. Hold 100 cycles → no further change. Release, then press again → mode=2, count=0.
- Step (PRESCALE=4, STEP_TICKS=25): count reaches 25 at cycle 100 → step=1 for exactly one cycle. Count stays 25 for 40 more cycles. Pulse count_clr_n low → count=0, then increments every 4 cycles.
- Clear vs tick collision: count_clr_n low on a wrap cycle with count=10 → count=0 next cycle, not 1.
- Off mode: mode=2 → count=0, step never pulses over 1000 cycles. A button press restores mode=0.
- GIRLANDA_AUTOCYCLE_EN with AUTO_STEPS=3, clr tied to step: three steps in mode 0 → mode=1. Three more → mode=0, never 2.
